alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the team's combinational 32-bit ALU. It registers all results and flags, accepts operations over a valid/ready interface, and adds a carry flag, an illegal-op flag and an iterative shift-add multiply mode. It sits between the register-read stage and writeback in the multicycle datapath, so the control FSM can stall on either side.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2.
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- A, B  in  WIDTH  operands (unsigned bit patterns; two's complement for flags).
- control  in  3  opcode: 000 MUL, 001 reserved, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 NOR, 111 XOR.
- out_valid  out  1  result register holds an undelivered result.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- out  out  WIDTH  registered result.
- overflow, zero, negative, carry, illegal  out  1 each  registered flags, aligned with out.
- busy  out  1  high while a MUL is iterating.

## Operation
- States: IDLE, MUL, HOLD.
- in_ready = (state==IDLE) && (!out_valid || out_ready), derived combinationally from registers and out_ready only.
- IDLE, accept of a non-MUL op: result and flags load; out_valid=1; state becomes HOLD, or stays IDLE-equivalent if drained (HOLD means out_valid=1 with no new accept possible this cycle). HOLD returns to IDLE on drain.
- IDLE, accept of MUL: latch A, B; clear the 2·WIDTH accumulator; counter=0; go to MUL.
- MUL: each cycle, if B_shift[0], add A_shift to the accumulator. A_shift shifts left, B_shift shifts right, and the counter increments. After WIDTH iterations, load out and flags, set out_valid, go to HOLD.
- ADD/SUB: out = A + (B ^ {WIDTH{sub}}) + sub.
  - carry = carry-out of MSB; for SUB, 1 means no borrow.
  - overflow = carry into MSB XOR carry-out of MSB.
- Logic ops: carry=0, overflow=0.
- MUL: out = low WIDTH bits of the unsigned product; overflow=1 iff the high WIDTH bits ≠ 0; carry=0.
- Reserved 001: out=0, illegal=1, other flags computed from out=0; 1-cycle latency. illegal=0 for every legal op.
- All ops: zero = (out==0); negative = out[WIDTH-1].
- out and flags are stable while out_valid && !out_ready.
- Reset (asynchronous, any state, including mid-MUL): state=IDLE; out_valid=0; busy=0; out=0; all flags=0; accumulator and counter=0. Any in-flight MUL is discarded with no output. in_ready=1 once reset_n is high.

## Timing
- Non-MUL latency: out_valid rises on the edge that accepts the operation (result visible the cycle after the accept cycle).
- MUL latency: out_valid rises WIDTH+1 edges after the accepting edge. busy=1 for exactly WIDTH cycles. in_ready=0 throughout.
- Throughput: one non-MUL op per cycle when out_ready is held high.
- Drain and accept on the same edge is permitted; the new result replaces the old one.
- in_valid without in_ready: nothing is captured; the producer must hold A, B and control.

## Configuration
- ALU_SEQ_MUL_EN:
  - Defined: MUL state, accumulator and counter are present as described.
  - Undefined: opcode 000 behaves exactly like 001 (illegal=1, out=0, 1-cycle latency). The MUL state and datapath are absent, and busy is tied to 0.

## Structure
- Shared package alu_pkg:
  - opcode enum alu_op_t (3-bit, encodings above);
  - state enum alu_seq_state_t;
  - localparams for opcode constants, used by the control FSM and the bench.
- Sub-module alu_seq_mul: the iterative shift-add unit, with start/done, parametrised by WIDTH, instantiated only under ALU_SEQ_MUL_EN.
- Add/sub/logic/flag generation is inline combinational logic feeding the result register.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+0x00000001 → out=0x80000000, overflow=1, negative=1, carry=0, zero=0, out_valid one cycle after accept.
- SUB 5−5 → out=0, zero=1, carry=1, overflow=0. SUB 0−1 → out=0xFFFFFFFF, carry=0, negative=1.
- MUL 0x00010000×0x00010000 → out=0, overflow=1, zero=1; busy high 32 cycles; out_valid at edge 33 after accept; in_ready low meanwhile. MUL 6×7 → out=42, overflow=0.
- Backpressure: out_ready=0, issue AND 0xF0F0F0F0,0xFF00FF00 then OR → first result 0xF000F000 held stable, in_ready=0, OR not accepted until out_ready pulses; then OR result 0xF0F0F0F0|B delivered.
- reset_n low at cycle 10 of a MUL → out_valid=0, busy=0, all flags 0 immediately. After release, ADD 2+3 → out=5, no stale MUL result ever appears.
- control=001 → illegal=1, out=0, zero=1. With ALU_SEQ_MUL_EN undefined, control=000 → same response, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state definitions for the sequential ALU and its bench.
package alu_pkg;

  localparam logic [2:0] OpcMul  = 3'b000;
  localparam logic [2:0] OpcRsvd = 3'b001;
  localparam logic [2:0] OpcAdd  = 3'b010;
  localparam logic [2:0] OpcSub  = 3'b011;
  localparam logic [2:0] OpcAnd  = 3'b100;
  localparam logic [2:0] OpcOr   = 3'b101;
  localparam logic [2:0] OpcNor  = 3'b110;
  localparam logic [2:0] OpcXor  = 3'b111;

  typedef enum logic [2:0] {
    OpMul  = OpcMul,
    OpRsvd = OpcRsvd,
    OpAdd  = OpcAdd,
    OpSub  = OpcSub,
    OpAnd  = OpcAnd,
    OpOr   = OpcOr,
    OpNor  = OpcNor,
    OpXor  = OpcXor
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StHold
  } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH iterations,
// then one cycle with done_o high while product_o holds the full 2*WIDTH result.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               run_q, run_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      a_d   = {{WIDTH{1'b0}}, a_i};
      b_d   = b_i;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q != CntMax) begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CntW'(1);
      end else begin
        // Result has been handed over on this edge.
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign busy_o    = run_q && (cnt_q != CntMax);
  assign done_o    = run_q && (cnt_q == CntMax);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with carry/illegal flags. Define ALU_SEQ_MUL_EN to
// include the iterative multiplier; otherwise opcode 000 is treated as illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             illegal,
  output logic             busy
);

  alu_seq_state_t state_q;
  alu_op_t        op;

  logic             accept, mul_accept, mul_done, is_sub;
  logic [WIDTH-1:0] b_x, alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_ovf, alu_carry, alu_ill;
  logic [2*WIDTH-1:0] mul_prod;

  assign op       = alu_op_t'(control);
  assign in_ready = (state_q == StIdle) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  assign mul_accept = accept && (op == OpMul);

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .start_i  (mul_accept),
    .a_i      (A),
    .b_i      (B),
    .busy_o   (busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );
`else
  assign mul_accept = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_prod   = '0;
  assign busy       = 1'b0;
`endif

  always_comb begin
    is_sub    = (op == OpSub);
    b_x       = B ^ {WIDTH{is_sub}};
    sum       = {1'b0, A} + {1'b0, b_x} + {{WIDTH{1'b0}}, is_sub};
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    alu_ill   = 1'b0;
    case (op)
      OpAdd, OpSub: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        // Carry into the MSB recovered from the MSB sum bit.
        alu_ovf   = (A[WIDTH-1] ^ b_x[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
      end
      OpAnd:   alu_res = A & B;
      OpOr:    alu_res = A | B;
      OpNor:   alu_res = ~(A | B);
      OpXor:   alu_res = A ^ B;
      default: alu_ill = 1'b1;
    endcase
  end

  // Non-MUL results stay in StIdle with out_valid set, so a drain and a new accept
  // can share an edge; StHold is only used after a MUL completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (mul_accept) begin
              state_q <= StMul;
            end else begin
              out       <= alu_res;
              overflow  <= alu_ovf;
              carry     <= alu_carry;
              illegal   <= alu_ill;
              zero      <= (alu_res == '0);
              negative  <= alu_res[WIDTH-1];
              out_valid <= 1'b1;
            end
          end
        end
        StMul: begin
          if (mul_done) begin
            out       <= mul_prod[WIDTH-1:0];
            overflow  <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
            carry     <= 1'b0;
            illegal   <= 1'b0;
            zero      <= (mul_prod[WIDTH-1:0] == '0);
            negative  <= mul_prod[WIDTH-1];
            out_valid <= 1'b1;
            state_q   <= StHold;
          end
        end
        StHold: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
